// File: rtl/lstm_fx_pkg.sv
// Shared fixed-point definitions for the LSTM gate MACs: Q format widths,
// saturation limits and the MAC controller state encoding.
package lstm_fx_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 16;

  localparam logic [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    OUT
  } mac_state_t;

endpackage

// File: rtl/fx_sat_shift.sv
// Drops the fractional bits of a wide accumulator (floor) and clips the
// result into a signed DATA_WIDTH word, flagging when clipping occurred.
module fx_sat_shift #(
  parameter int ACC_WIDTH  = 68,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic        [DATA_WIDTH-1:0] res,
  output logic                         sat
);

  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] y;

  always_comb begin
    y   = acc >>> FRAC_BITS;
    res = y[DATA_WIDTH-1:0];
    sat = 1'b0;
    if (y > Y_MAX) begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat = 1'b1;
    end else if (y < Y_MIN) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/row_dot_product.sv
// Per-gate MAC: reads one full row from the row buffer, multiplies it with a
// streamed weight vector, adds the bias and emits one saturated Q result.
module row_dot_product #(
  parameter int DATA_WIDTH = lstm_fx_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_SIZE   = 4,
  parameter int FRAC_BITS  = lstm_fx_pkg::FRAC_BITS,
  parameter int ACC_WIDTH  = 68
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  row_done,
  input  logic [DATA_WIDTH-1:0] row_dout,
  output logic                  row_rd_en,
  output logic [ADDR_WIDTH-1:0] row_rd_addr,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_ready,
  output logic                  sat_flag,
  output logic                  busy,
  output logic                  err_abort
);

  import lstm_fx_pkg::*;

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_SIZE - 1);

  mac_state_t state, state_next;

  logic [ADDR_WIDTH-1:0]        idx;
  logic signed [PROD_WIDTH-1:0] prod_q;
  logic signed [PROD_WIDTH-1:0] prod_next;
  logic                         prod_vld;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  bias_acc;
  logic [DATA_WIDTH-1:0]        sat_res;
  logic                         sat_hit;
  logic                         handshake;

  assign row_rd_addr = idx;
  assign busy        = (state != IDLE);
  assign handshake   = (state == READ) && row_done && w_valid;
  assign prod_next   = PROD_WIDTH'($signed(row_dout)) * PROD_WIDTH'($signed(w_data));
  assign bias_acc    = ACC_WIDTH'($signed(bias)) <<< FRAC_BITS;
  // The product register lags by one cycle, so the accumulator always adds the previous product.
  assign acc_sum     = acc + (prod_vld ? ACC_WIDTH'(prod_q) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    row_rd_en  = 1'b0;
    w_ready    = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (row_done) state_next = READ;
      end
      READ: begin
        row_rd_en = w_valid;
        w_ready   = w_valid;
        if (!row_done)                      state_next = IDLE;
        else if (w_valid && idx == LAST_IDX) state_next = FLUSH;
      end
      FLUSH: begin
        state_next = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      prod_q    <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      res_data  <= '0;
      sat_flag  <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      err_abort <= (state == READ) && !row_done;
      case (state)
        IDLE: begin
          acc      <= bias_acc;
          idx      <= '0;
          prod_vld <= 1'b0;
        end
        READ: begin
          acc      <= acc_sum;
          prod_vld <= handshake;
          if (handshake) begin
            prod_q <= prod_next;
            idx    <= idx + 1'b1;
          end
        end
        FLUSH: begin
          acc      <= acc_sum;
          prod_vld <= 1'b0;
          res_data <= sat_res;
          sat_flag <= sat_hit;
        end
        default: ;
      endcase
    end
  end

  // The result is taken from the sum including the last product, on the FLUSH->OUT edge.
  fx_sat_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .acc(acc_sum),
    .res(sat_res),
    .sat(sat_hit)
  );

endmodule
